// File: rtl/aes_word_loader.sv
// aes_word_loader: stream shell around the combinational aes_encryption core.
//   Gathers a 256-bit key and a 128-bit plaintext from 32-bit valid/ready
//   words. It holds them stable on key_o/plaintext_o for SETTLE_CYCLES cycles,
//   captures ciphertext_i, then returns the result as four 32-bit words.
//   A frame marked plaintext-only on word 0 reuses the stored key.
// Ports:
//   clk_i, reset_i               clock, async active-high reset
//   in_v_i/in_ready_o            input word handshake (in_data_i, in_plain_only_i)
//   key_o, plaintext_o           stable operands to the core
//   ciphertext_i                 core result
//   out_v_o/out_ready_i          output word handshake (out_data_o, out_last_o)
//   busy_o                       high while settling or sending
//   err_o                        one-cycle pulse: plaintext-only frame with no key
module aes_word_loader #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         in_v_i,
  input  logic [31:0]  in_data_i,
  input  logic         in_plain_only_i,
  output logic         in_ready_o,
  output logic [255:0] key_o,
  output logic [127:0] plaintext_o,
  input  logic [127:0] ciphertext_i,
  output logic         out_v_o,
  output logic [31:0]  out_data_o,
  output logic         out_last_o,
  input  logic         out_ready_i,
  output logic         busy_o,
  output logic         err_o
);

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {RECV, SETTLE, SEND} state_t;

  state_t             state_q, state_d;
  // Word counter: 0..7 are key words, 8..11 are plaintext words. A
  // plaintext-only frame jumps straight into the 8..11 range, so one
  // counter covers both frame kinds.
  logic [3:0]         cnt_q;
  logic               key_valid_q;
  logic [7:0][31:0]   key_q;   // [7] is the most significant word
  logic [3:0][31:0]   pt_q;
  logic [3:0][31:0]   ct_q;
  logic [7:0]         settle_q;
  logic [1:0]         idx_q;
  logic               err_q;

  logic in_fire, out_fire;

  assign in_ready_o  = (state_q == RECV);
  assign busy_o      = (state_q != RECV);
  assign out_v_o     = (state_q == SEND);
  assign out_last_o  = out_v_o & (idx_q == 2'd3);
  assign out_data_o  = out_v_o ? ct_q[2'd3 - idx_q] : 32'd0;
  assign key_o       = key_q;
  assign plaintext_o = pt_q;
  assign err_o       = err_q;

  assign in_fire  = in_v_i & in_ready_o;
  assign out_fire = out_v_o & out_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= RECV;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV:    if (in_fire && cnt_q == 4'd11) state_d = SETTLE;
      SETTLE:  if (settle_q == 8'd0)          state_d = SEND;
      SEND:    if (out_fire && idx_q == 2'd3) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_q       <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      settle_q    <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        RECV: begin
          if (in_fire) begin
            if (cnt_q == 4'd0 && in_plain_only_i) begin
              // Plaintext-only start: needs a stored key, otherwise the
              // word is dropped and the frame never opens.
              if (key_valid_q) begin
                pt_q[3] <= in_data_i;
                cnt_q   <= 4'd9;
              end else begin
                err_q <= 1'b1;
              end
            end else if (cnt_q < 4'd8) begin
              key_q[3'd7 - cnt_q[2:0]] <= in_data_i;
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) key_valid_q <= 1'b1;
            end else begin
              pt_q[2'd3 - cnt_q[1:0]] <= in_data_i;
              if (cnt_q == 4'd11) begin
                cnt_q    <= '0;
                settle_q <= SETTLE_INIT;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
        end
        SETTLE: begin
          if (settle_q == 8'd0) begin
            ct_q  <= ciphertext_i;
            idx_q <= 2'd0;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        SEND: begin
          if (out_fire) idx_q <= idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// Bench for aes_word_loader. A behavioural stand-in for the AES core answers
// the FIPS-197 AES-256 vector exactly; any other operand pair gets a cheap
// XOR mix. Stimulus pushes expected output words into a queue, and a
// negedge monitor pops and compares them on every output handshake.
module tb_aes_word_loader;
  localparam int SETTLE = 16;

  localparam logic [255:0] K  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P2 = 128'hcafef00d123456780badbeef55aa55aa;

  logic         clk_i = 0, reset_i = 0;
  logic         in_v_i = 0, in_plain_only_i = 0, out_ready_i = 1;
  logic [31:0]  in_data_i = 0;
  logic         in_ready_o, out_v_o, out_last_o, busy_o, err_o;
  logic [255:0] key_o;
  logic [127:0] plaintext_o, ciphertext_i;
  logic [31:0]  out_data_o;

  aes_word_loader #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_v_i(in_v_i), .in_data_i(in_data_i),
    .in_plain_only_i(in_plain_only_i), .in_ready_o(in_ready_o), .key_o(key_o),
    .plaintext_o(plaintext_o), .ciphertext_i(ciphertext_i), .out_v_o(out_v_o),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] core_model(logic [255:0] k, logic [127:0] p);
    if (k == K && p == P) return CT;
    return p ^ k[255:128] ^ k[127:0];
  endfunction

  assign ciphertext_i = core_model(key_o, plaintext_o);

  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0;
  logic prev_v = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_ct(input logic [127:0] c);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d = c[127-32*i -: 32];
      e.l = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every output handshake against the scoreboard and
  // checks the settle latency on each rise of out_v_o.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (out_v_o && !prev_v) chk("latency", 256'(cyc - acc_cyc), 256'(SETTLE));
      if (out_v_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output act=%h exp=none", out_data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 256'(out_data_o), 256'(e.d));
          chk("out_last", 256'(out_last_o), 256'(e.l));
        end
      end
    end
    prev_v = out_v_o;
  end

  // Drive one word and hold it until the loader takes it.
  task automatic send_word(input logic [31:0] w, input logic po);
    int n = 0;
    in_v_i = 1; in_data_i = w; in_plain_only_i = po;
    @(negedge clk_i);
    while (!in_ready_o && n < 200) begin n++; @(negedge clk_i); end
    if (!in_ready_o) chk("in_ready_timeout", 256'(in_ready_o), 256'd1);
    @(posedge clk_i); #1;
    acc_cyc = cyc;
    in_v_i = 0; in_plain_only_i = 0;
  endtask

  task automatic full_frame(input logic [255:0] k, input logic [127:0] p, input bit gaps);
    logic [31:0] w;
    push_ct(core_model(k, p));
    for (int i = 0; i < 12; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
      w = (i < 8) ? k[255-32*i -: 32] : p[127-32*(i-8) -: 32];
      send_word(w, 1'b0);
    end
  endtask

  task automatic pt_frame(input logic [127:0] p);
    push_ct(core_model(K, p));
    for (int i = 0; i < 4; i++) send_word(p[127-32*i -: 32], i == 0);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk_i);
    while ((exp_q.size() != 0 || busy_o) && n < 500) begin n++; @(negedge clk_i); end
    chk("drain", 256'(exp_q.size()), 256'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    reset_i = 1; #3; reset_i = 0;
    exp_q.delete();
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2; reset_i = 1; #10; reset_i = 0;
    @(posedge clk_i); #1;
    // reset state
    chk("rst_key", key_o, 256'd0);
    chk("rst_pt", 256'(plaintext_o), 256'd0);
    chk("rst_out_v", 256'(out_v_o), 256'd0);
    chk("rst_out_last", 256'(out_last_o), 256'd0);
    chk("rst_out_data", 256'(out_data_o), 256'd0);
    chk("rst_err", 256'(err_o), 256'd0);
    chk("rst_busy", 256'(busy_o), 256'd0);
    chk("rst_in_ready", 256'(in_ready_o), 256'd1);

    // plaintext-only with no stored key: error pulse, word dropped
    send_word(32'h00112233, 1'b1);
    chk("err_pulse", 256'(err_o), 256'd1);
    chk("err_busy", 256'(busy_o), 256'd0);
    @(posedge clk_i); #1;
    chk("err_one_cycle", 256'(err_o), 256'd0);
    repeat (SETTLE + 4) @(posedge clk_i);
    #1;
    chk("err_no_output", 256'(out_v_o), 256'd0);

    // full frame, FIPS-197 vector
    full_frame(K, P, 1'b0);
    wait_done();
    chk("key_after_full", key_o, K);

    // plaintext-only reuse of the stored key
    pt_frame(P);
    wait_done();
    chk("key_reused", key_o, K);

    // backpressure on output word 1
    pt_frame(P);
    n = 0;
    @(negedge clk_i);
    while (!out_v_o && n < 100) begin n++; @(negedge clk_i); end
    chk("stall_out_v_seen", 256'(out_v_o), 256'd1);
    @(posedge clk_i); #1;
    out_ready_i = 0;
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_data", 256'(out_data_o), 256'h516745bf);
      chk("stall_v", 256'(out_v_o), 256'd1);
      chk("stall_in_ready", 256'(in_ready_o), 256'd0);
    end
    @(posedge clk_i); #1;
    out_ready_i = 1;
    wait_done();

    // gaps on input; in_v_i held high through SETTLE is ignored
    full_frame(K, P, 1'b1);
    in_v_i = 1; in_data_i = 32'hdeadbeef;
    repeat (8) begin
      @(negedge clk_i);
      chk("settle_in_ready", 256'(in_ready_o), 256'd0);
      chk("settle_busy", 256'(busy_o), 256'd1);
    end
    chk("settle_key_hold", key_o, K);
    @(posedge clk_i); #1;
    in_v_i = 0;
    wait_done();

    // key reuse with a different plaintext
    pt_frame(P2);
    wait_done();

    // asynchronous reset in the middle of SETTLE
    full_frame(K, P, 1'b0);
    repeat (3) @(posedge clk_i);
    #3; reset_i = 1; #1;
    chk("arst_key", key_o, 256'd0);
    chk("arst_pt", 256'(plaintext_o), 256'd0);
    chk("arst_out_v", 256'(out_v_o), 256'd0);
    chk("arst_busy", 256'(busy_o), 256'd0);
    exp_q.delete();
    #2; reset_i = 0;
    repeat (SETTLE + 10) @(posedge clk_i);
    #1;
    chk("arst_no_output", 256'(out_v_o), 256'd0);
    full_frame(K, P, 1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
